// File: rtl/common_pkg.sv
// ============================================================================
//  Module      : common_pkg
//  Description : Shared types and defaults for the clock UI path.
//                con_op_t   - raw/debounced push-button levels (1 = pressed)
//                clock_op_t - single-cycle command pulses to the clock core
//                ui_mode_t  - UI mode of the button controller
//                *_DEFAULT  - default timing constants for button_op_ctrl
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package common_pkg;

    // Bit order (MSB..LSB): display, set_time, set_alarm, toggle_alarm, left, up
    typedef struct packed {
        logic display;
        logic set_time;
        logic set_alarm;
        logic toggle_alarm;
        logic left;
        logic up;
    } con_op_t;

    typedef struct packed {
        logic clock_do_display_time;
        logic clock_do_set_time;
        logic clock_do_set_alarm;
        logic clock_do_toggle_alarm;
        logic clock_do_left;
        logic clock_do_up;
    } clock_op_t;

    typedef enum logic [1:0] {
        MODE_DISPLAY   = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } ui_mode_t;

    localparam int DEB_CYCLES_DEFAULT    = 20000;
    localparam int HOLD_CYCLES_DEFAULT   = 500000;
    localparam int REPEAT_CYCLES_DEFAULT = 100000;
    localparam int CNT_W_DEFAULT         = 20;

endpackage : common_pkg

`default_nettype wire

// File: rtl/button_debounce.sv
// ============================================================================
//  Module      : button_debounce
//  Description : One button channel: 2-flop synchroniser, counter debounce
//                and rising-edge (press) detection.
//  Ports       : clk     - system clock
//                rst     - synchronous active-high reset
//                i_raw   - raw asynchronous button level
//                o_db    - debounced level
//                o_rise  - high for the one cycle in which o_db goes 0 -> 1
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debounce #(
    parameter int DEB_CYCLES = 20000,
    parameter int CNT_W      = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_db,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       r_sync;
    logic             r_db;
    logic             r_db_prev;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= 2'b00;
            r_db      <= 1'b0;
            r_db_prev <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync    <= {r_sync[0], i_raw};
            r_db_prev <= r_db;
            if (r_sync[1] != r_db) begin
                // The level must disagree for DEB_CYCLES consecutive samples
                // before it is accepted; any agreeing sample restarts the run.
                if (r_cnt == c_deb_last) begin
                    r_db  <= r_sync[1];
                    r_cnt <= '0;
                end else if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_db   = r_db;
    assign o_rise = r_db & ~r_db_prev;

endmodule : button_debounce

`default_nettype wire

// File: rtl/button_op_ctrl.sv
// ============================================================================
//  Module      : button_op_ctrl
//  Description : Converts raw push-button levels into clean single-cycle
//                clock commands: per-button debounce, UI mode FSM, priority
//                resolution of simultaneous mode presses and optional
//                press-and-hold auto-repeat on "up".
//  Ports       : clk        - system clock
//                rst        - synchronous active-high reset
//                but_i      - raw button levels (con_op_t, 1 = pressed)
//                op_o       - registered one-cycle command pulses (clock_op_t)
//                mode_o     - current UI mode
//                alarm_en_o - alarm-armed flag
//                but_db_o   - debounced button levels, con_op_t bit order
//  Options     : BUTTON_AUTOREPEAT_EN - when defined, holding "up" in a set
//                mode produces a first repeat after HOLD_CYCLES and then one
//                pulse every REPEAT_CYCLES; otherwise one pulse per press.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_op_ctrl
    import common_pkg::*;
#(
    parameter int DEB_CYCLES    = DEB_CYCLES_DEFAULT,
    parameter int HOLD_CYCLES   = HOLD_CYCLES_DEFAULT,
    parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEFAULT,
    parameter int CNT_W         = CNT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  con_op_t    but_i,
    output clock_op_t  op_o,
    output ui_mode_t   mode_o,
    output logic       alarm_en_o,
    output logic [5:0] but_db_o
);

    logic [5:0] w_raw;
    logic [5:0] w_db;
    logic [5:0] w_rise;
    con_op_t    w_press;
    con_op_t    w_db_lvl;

    assign w_raw = but_i;

    for (genvar gi = 0; gi < 6; gi++) begin : g_chan
        button_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .CNT_W      (CNT_W)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .i_raw  (w_raw[gi]),
            .o_db   (w_db[gi]),
            .o_rise (w_rise[gi])
        );
    end

    assign w_press  = con_op_t'(w_rise);
    assign w_db_lvl = con_op_t'(w_db);
    assign but_db_o = w_db;

    ui_mode_t  r_mode;
    ui_mode_t  w_mode_next;
    clock_op_t r_op;
    clock_op_t w_op;
    logic      r_alarm_en;
    logic      w_mode_hit;
    logic      w_set_mode;
    logic      w_up_accept;
    logic      w_rep_fire;

    // Any mode button press, including a re-press of the current mode.
    assign w_mode_hit = w_press.display | w_press.set_time | w_press.set_alarm;

    always_comb begin
        w_mode_next = r_mode;
        w_op        = '0;
        // Priority: display > set_time > set_alarm.
        if (w_press.display) begin
            w_mode_next                = MODE_DISPLAY;
            w_op.clock_do_display_time = 1'b1;
        end else if (w_press.set_time) begin
            w_mode_next            = MODE_SET_TIME;
            w_op.clock_do_set_time = 1'b1;
        end else if (w_press.set_alarm) begin
            w_mode_next             = MODE_SET_ALARM;
            w_op.clock_do_set_alarm = 1'b1;
        end
        w_op.clock_do_toggle_alarm = w_press.toggle_alarm;
        // left/up are judged against the mode being entered this cycle.
        w_set_mode         = (w_mode_next != MODE_DISPLAY);
        w_up_accept        = w_press.up & w_set_mode;
        w_op.clock_do_left = w_press.left & w_set_mode;
        w_op.clock_do_up   = (w_press.up | w_rep_fire) & w_set_mode;
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] c_hold   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] c_period = CNT_W'(REPEAT_CYCLES);

    logic             r_rep_arm;  // an accepted up press is being held
    logic             r_rep_run;  // hold phase over, periodic phase active
    logic [CNT_W-1:0] r_rep_cnt;

    // Counter holds the number of cycles since the press (or last repeat),
    // so it equals 1 in the cycle the press pulse is on op_o.
    always_comb begin
        w_rep_fire = 1'b0;
        if (r_rep_arm && w_db_lvl.up && !w_mode_hit) begin
            w_rep_fire = r_rep_run ? (r_rep_cnt == c_period)
                                   : (r_rep_cnt == c_hold);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rep_arm <= 1'b0;
            r_rep_run <= 1'b0;
            r_rep_cnt <= '0;
        end else if (w_up_accept) begin
            r_rep_arm <= 1'b1;
            r_rep_run <= 1'b0;
            r_rep_cnt <= CNT_W'(1);
        end else if (w_mode_hit || !w_db_lvl.up) begin
            r_rep_arm <= 1'b0;
            r_rep_run <= 1'b0;
            r_rep_cnt <= '0;
        end else if (r_rep_arm) begin
            if (w_rep_fire) begin
                r_rep_run <= 1'b1;
                r_rep_cnt <= CNT_W'(1);
            end else if (r_rep_cnt != '1) begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
            end
        end
    end
`else
    logic w_unused_rep;
    assign w_unused_rep = ^{32'(HOLD_CYCLES), 32'(REPEAT_CYCLES)};
    assign w_rep_fire   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode     <= MODE_DISPLAY;
            r_op       <= '0;
            r_alarm_en <= 1'b0;
        end else begin
            r_mode     <= w_mode_next;
            r_op       <= w_op;
            r_alarm_en <= r_alarm_en ^ w_press.toggle_alarm;
        end
    end

    assign op_o       = r_op;
    assign mode_o     = r_mode;
    assign alarm_en_o = r_alarm_en;

endmodule : button_op_ctrl

`default_nettype wire

// File: tb/tb_button_op_ctrl.sv
// ============================================================================
//  Module      : tb_button_op_ctrl
//  Description : Self-checking bench for button_op_ctrl with short timing
//                (DEB=4, HOLD=16, REPEAT=8). Expected op_o pulses are queued
//                by cycle when stimulus is applied and compared each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_op_ctrl;
    import common_pkg::*;

    localparam int c_deb   = 4;
    localparam int c_hold  = 16;
    localparam int c_rep   = 8;
    localparam int c_cnt_w = 20;
    localparam int c_lat   = c_deb + 3;

    localparam logic [5:0] c_m_disp   = 6'b100000;
    localparam logic [5:0] c_m_stime  = 6'b010000;
    localparam logic [5:0] c_m_salarm = 6'b001000;
    localparam logic [5:0] c_m_tog    = 6'b000100;
    localparam logic [5:0] c_m_left   = 6'b000010;
    localparam logic [5:0] c_m_up     = 6'b000001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] tb_but = 6'h00;
    logic [5:0] op;
    logic [5:0] db;
    ui_mode_t   mode;
    logic       alarm_en;

    always #5 clk = ~clk;

    button_op_ctrl #(
        .DEB_CYCLES    (c_deb),
        .HOLD_CYCLES   (c_hold),
        .REPEAT_CYCLES (c_rep),
        .CNT_W         (c_cnt_w)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .but_i      (con_op_t'(tb_but)),
        .op_o       (op),
        .mode_o     (mode),
        .alarm_en_o (alarm_en),
        .but_db_o   (db)
    );

    typedef struct {
        int         cyc;
        logic [5:0] op;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    // Insert an expected op_o value for a given cycle, keeping the queue sorted.
    task automatic expect_op(input int at, input logic [5:0] m);
        exp_t e;
        e.cyc = at;
        e.op  = m;
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc == at) begin
                sb[i].op = sb[i].op | m;
                return;
            end else if (sb[i].cyc > at) begin
                sb.insert(i, e);
                return;
            end
        end
        sb.push_back(e);
    endtask

    // Advance one clock; sample on the falling edge and score op_o.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            e = sb.pop_front();
            check_eq("op", 32'(op), 32'(e.op));
        end else begin
            check_eq("op_idle", 32'(op), 32'd0);
        end
    endtask

    task automatic hold(input logic [5:0] m, input int n);
        tb_but = tb_but | m;
        repeat (n) step();
        tb_but = tb_but & ~m;
    endtask

    task automatic settle(input int n);
        repeat (n) step();
    endtask

    initial begin
        int c0;

        // Reset with every button pressed.
        tb_but = 6'h3F;
        rst    = 1'b1;
        repeat (3) begin
            step();
            check_eq("rst_mode", 32'(mode), 32'(MODE_DISPLAY));
            check_eq("rst_alarm", 32'(alarm_en), 32'd0);
            check_eq("rst_db", 32'(db), 32'd0);
        end
        rst    = 1'b0;
        tb_but = 6'h00;
        step();
        check_eq("post_rst_mode", 32'(mode), 32'(MODE_DISPLAY));
        check_eq("post_rst_alarm", 32'(alarm_en), 32'd0);

        // set_time press: pulse and mode change exactly DEB+3 cycles later.
        c0 = cyc;
        expect_op(c0 + c_lat, c_m_stime);
        tb_but = tb_but | c_m_stime;
        repeat (c_lat - 1) step();
        check_eq("mode_before", 32'(mode), 32'(MODE_DISPLAY));
        step();
        check_eq("mode_set_time", 32'(mode), 32'(MODE_SET_TIME));
        repeat (3) step();
        tb_but = tb_but & ~c_m_stime;
        settle(12);

        // 3-cycle up glitch never reaches the debounced level.
        hold(c_m_up, 3);
        repeat (8) begin
            step();
            check_eq("db_up_glitch", 32'(db[0]), 32'd0);
        end

        // up held 40 cycles in MODE_SET_TIME.
        c0 = cyc;
        expect_op(c0 + c_lat, c_m_up);
`ifdef BUTTON_AUTOREPEAT_EN
        expect_op(c0 + c_lat + c_hold, c_m_up);
        expect_op(c0 + c_lat + c_hold + c_rep, c_m_up);
        expect_op(c0 + c_lat + c_hold + 2 * c_rep, c_m_up);
`endif
        tb_but = tb_but | c_m_up;
        repeat (20) step();
        check_eq("db_up_held", 32'(db[0]), 32'd1);
        repeat (20) step();
        tb_but = tb_but & ~c_m_up;
        settle(15);

        // display and set_alarm together: display wins.
        expect_op(cyc + c_lat, c_m_disp);
        hold(c_m_disp | c_m_salarm, 10);
        check_eq("mode_prio", 32'(mode), 32'(MODE_DISPLAY));
        settle(12);

        // left in MODE_DISPLAY is ignored.
        hold(c_m_left, 10);
        settle(12);
        check_eq("mode_left", 32'(mode), 32'(MODE_DISPLAY));

        // toggle_alarm twice: alarm flips with the pulse.
        for (int k = 0; k < 2; k++) begin
            c0 = cyc;
            expect_op(c0 + c_lat, c_m_tog);
            tb_but = tb_but | c_m_tog;
            repeat (c_lat - 1) step();
            check_eq("alarm_before", 32'(alarm_en), 32'(k));
            step();
            check_eq("alarm_after", 32'(alarm_en), 32'(1 - k));
            repeat (3) step();
            tb_but = tb_but & ~c_m_tog;
            settle(12);
        end

        // Enter MODE_SET_TIME, hold up into repeat, then press set_alarm.
        expect_op(cyc + c_lat, c_m_stime);
        hold(c_m_stime, 10);
        settle(12);
        c0 = cyc;
        expect_op(c0 + c_lat, c_m_up);
`ifdef BUTTON_AUTOREPEAT_EN
        expect_op(c0 + c_lat + c_hold, c_m_up);
        expect_op(c0 + c_lat + c_hold + c_rep, c_m_up);
`endif
        tb_but = tb_but | c_m_up;
        repeat (26) step();
        expect_op(cyc + c_lat, c_m_salarm);
        tb_but = tb_but | c_m_salarm;
        repeat (10) step();
        tb_but = tb_but & ~c_m_salarm;
        repeat (24) step();
        check_eq("mode_set_alarm", 32'(mode), 32'(MODE_SET_ALARM));
        tb_but = tb_but & ~c_m_up;
        settle(12);

        // Re-press up in MODE_SET_ALARM gives a fresh pulse.
        expect_op(cyc + c_lat, c_m_up);
        hold(c_m_up, 10);
        settle(12);

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_button_op_ctrl

`default_nettype wire
